// File: rtl/snake_pkg.sv
// Shared snake-game types and default playfield geometry.
package snake_pkg;

   localparam int GRID_W  = 16;
   localparam int GRID_H  = 12;
   localparam int MAX_LEN = 64;
   localparam int XW      = $clog2(GRID_W) + 1;
   localparam int YW      = $clog2(GRID_H) + 1;
   localparam int LW      = $clog2(MAX_LEN) + 1;

   typedef logic [XW-1:0] coord_x_t;
   typedef logic [YW-1:0] coord_y_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WALL   = 2'd1,
      SCAN   = 2'd2,
      REPORT = 2'd3
   } coll_state_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      GOOD = 2'd1,
      BAD  = 2'd2
   } coll_result_e;

endpackage

// File: rtl/collision_checker.sv
// Checks a new snake head against walls, the body (read serially from the
// body store) and the apple; emits one done pulse with good/bad per check.
//
// state  | meaning
// IDLE   | ready for a request; latches head/apple/length on accept
// WALL   | cycle 1 registers wall/apple compares, cycle 2 decides
// SCAN   | streams body reads, compares each returned segment to the head
// REPORT | done (+ goodColl/badColl) high for this cycle only
module collision_checker #(
   parameter int GRID_W  = snake_pkg::GRID_W,
   parameter int GRID_H  = snake_pkg::GRID_H,
   parameter int MAX_LEN = snake_pkg::MAX_LEN,
   parameter int XW      = $clog2(GRID_W) + 1,
   parameter int YW      = $clog2(GRID_H) + 1,
   parameter int LW      = $clog2(MAX_LEN) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          check_valid,
   output logic          check_ready,
   input  logic [XW-1:0] head_x,
   input  logic [YW-1:0] head_y,
   input  logic [XW-1:0] apple_x,
   input  logic [YW-1:0] apple_y,
   input  logic [LW-1:0] snake_len,
   output logic          body_rd_en,
   output logic [LW-1:0] body_rd_addr,
   input  logic [XW-1:0] body_x,
   input  logic [YW-1:0] body_y,
   output logic          goodColl,
   output logic          badColl,
   output logic          done
);

   localparam logic [XW-1:0] X_LIM   = XW'(GRID_W);
   localparam logic [YW-1:0] Y_LIM   = YW'(GRID_H);
   localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

   snake_pkg::coll_state_e  state_q, state_d;
   snake_pkg::coll_result_e res_q, res_d;
   logic [XW-1:0] hx_q, hx_d, ax_q, ax_d;
   logic [YW-1:0] hy_q, hy_d, ay_q, ay_d;
   logic [LW-1:0] len_q, len_d, issue_q, issue_d, rd_addr_q, rd_addr_d;
   logic          wall_eval_q, wall_eval_d;
   logic          wall_hit_q, wall_hit_d, apple_hit_q, apple_hit_d;
   logic          rd_en_q, rd_en_d, data_vld_q, data_vld_d;
   logic          good_q, good_d, bad_q, bad_d, done_q, done_d;
   logic          body_hit;

   assign check_ready  = (state_q == snake_pkg::IDLE);
   assign body_rd_en   = rd_en_q;
   assign body_rd_addr = rd_addr_q;
   assign goodColl     = good_q;
   assign badColl      = bad_q;
   assign done         = done_q;

   assign body_hit = data_vld_q && (body_x == hx_q) && (body_y == hy_q);

   // Next-state, read issue and result decode.
   always_comb begin
      state_d     = state_q;
      res_d       = res_q;
      hx_d        = hx_q;
      hy_d        = hy_q;
      ax_d        = ax_q;
      ay_d        = ay_q;
      len_d       = len_q;
      issue_d     = issue_q;
      rd_addr_d   = rd_addr_q;
      rd_en_d     = 1'b0;
      wall_eval_d = 1'b0;
      wall_hit_d  = wall_hit_q;
      apple_hit_d = apple_hit_q;
      case (state_q)
         snake_pkg::IDLE: begin
            if (check_valid) begin
               hx_d    = head_x;
               hy_d    = head_y;
               ax_d    = apple_x;
               ay_d    = apple_y;
               len_d   = (snake_len > LEN_MAX) ? LEN_MAX : snake_len;
               res_d   = snake_pkg::NONE;
               state_d = snake_pkg::WALL;
            end
         end
         snake_pkg::WALL: begin
            if (!wall_eval_q) begin
               wall_eval_d = 1'b1;
               wall_hit_d  = (hx_q >= X_LIM) || (hy_q >= Y_LIM);
               apple_hit_d = (hx_q == ax_q) && (hy_q == ay_q);
            end else if (wall_hit_q) begin
               res_d   = snake_pkg::BAD;
               state_d = snake_pkg::REPORT;
            end else if (len_q == '0) begin
               res_d   = apple_hit_q ? snake_pkg::GOOD : snake_pkg::NONE;
               state_d = snake_pkg::REPORT;
            end else begin
               rd_en_d   = 1'b1;
               rd_addr_d = '0;
               issue_d   = LW'(1);
               state_d   = snake_pkg::SCAN;
            end
         end
         snake_pkg::SCAN: begin
            if (body_hit) begin
               res_d   = snake_pkg::BAD;
               state_d = snake_pkg::REPORT;
            end else if (issue_q < len_q) begin
               rd_en_d   = 1'b1;
               rd_addr_d = issue_q;
               issue_d   = issue_q + LW'(1);
            end else if (!rd_en_q && !data_vld_q) begin
               // every segment has been compared without a match
               res_d   = apple_hit_q ? snake_pkg::GOOD : snake_pkg::NONE;
               state_d = snake_pkg::REPORT;
            end
         end
         snake_pkg::REPORT: state_d = snake_pkg::IDLE;
         default:           state_d = snake_pkg::IDLE;
      endcase
      data_vld_d = rd_en_q && (state_d == snake_pkg::SCAN);
      done_d     = (state_d == snake_pkg::REPORT);
      good_d     = done_d && (res_d == snake_pkg::GOOD);
      bad_d      = done_d && (res_d == snake_pkg::BAD);
   end

   // State and datapath registers; reset aborts any check in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= snake_pkg::IDLE;
         res_q       <= snake_pkg::NONE;
         hx_q        <= '0;
         hy_q        <= '0;
         ax_q        <= '0;
         ay_q        <= '0;
         len_q       <= '0;
         issue_q     <= '0;
         rd_addr_q   <= '0;
         rd_en_q     <= 1'b0;
         data_vld_q  <= 1'b0;
         wall_eval_q <= 1'b0;
         wall_hit_q  <= 1'b0;
         apple_hit_q <= 1'b0;
         good_q      <= 1'b0;
         bad_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         hx_q        <= hx_d;
         hy_q        <= hy_d;
         ax_q        <= ax_d;
         ay_q        <= ay_d;
         len_q       <= len_d;
         issue_q     <= issue_d;
         rd_addr_q   <= rd_addr_d;
         rd_en_q     <= rd_en_d;
         data_vld_q  <= data_vld_d;
         wall_eval_q <= wall_eval_d;
         wall_hit_q  <= wall_hit_d;
         apple_hit_q <= apple_hit_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_collision_checker.sv
// Randomized scoreboard bench for collision_checker with a body-store model.
module tb_collision_checker;

   localparam int XW   = 5;
   localparam int YW   = 5;
   localparam int LW   = 7;
   localparam int MAXL = 64;
   localparam int GW   = 16;
   localparam int GH   = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          check_valid = 1'b0;
   logic          check_ready;
   logic [XW-1:0] head_x = '0, apple_x = '0, body_x = '0;
   logic [YW-1:0] head_y = '0, apple_y = '0, body_y = '0;
   logic [LW-1:0] snake_len = '0;
   logic          body_rd_en;
   logic [LW-1:0] body_rd_addr;
   logic          goodColl, badColl, done;

   // res: 0 none, 1 good, 2 bad; lat: edges after accept; reads issued
   typedef struct {
      int res;
      int lat;
      int reads;
   } exp_t;

   exp_t sbq[$];
   int   bx[MAXL];
   int   by[MAXL];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   rd_cnt = 0;
   int   done_seen = 0;
   int   acc_seen = 0;
   bit   addr_bad = 1'b0;

   collision_checker dut (
      .clk          (clk),
      .rst          (rst),
      .check_valid  (check_valid),
      .check_ready  (check_ready),
      .head_x       (head_x),
      .head_y       (head_y),
      .apple_x      (apple_x),
      .apple_y      (apple_y),
      .snake_len    (snake_len),
      .body_rd_en   (body_rd_en),
      .body_rd_addr (body_rd_addr),
      .body_x       (body_x),
      .body_y       (body_y),
      .goodColl     (goodColl),
      .badColl      (badColl),
      .done         (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // body store: synchronous read, data one cycle after the strobe
   always @(posedge clk) begin
      if (body_rd_en) begin
         body_x <= XW'(bx[body_rd_addr[5:0]]);
         body_y <= YW'(by[body_rd_addr[5:0]]);
      end
   end

   function automatic exp_t model(input int hx, input int hy, input int ax,
                                  input int ay, input int len_in);
      exp_t e;
      int   len;
      len = (len_in > MAXL) ? MAXL : len_in;
      if (hx >= GW || hy >= GH) begin
         e.res = 2; e.lat = 2; e.reads = 0;
         return e;
      end
      for (int k = 0; k < len; k++) begin
         if (bx[k] == hx && by[k] == hy) begin
            e.res = 2; e.lat = k + 4; e.reads = (k + 2 < len) ? k + 2 : len;
            return e;
         end
      end
      e.res   = (hx == ax && hy == ay) ? 1 : 0;
      e.lat   = (len == 0) ? 2 : len + 4;
      e.reads = len;
      return e;
   endfunction

   // monitor: pops the scoreboard on every done pulse
   always @(negedge clk) begin
      exp_t e;
      int   got;
      if (rst) begin
         sbq.delete();
      end else begin
         if (body_rd_en) begin
            if (int'(body_rd_addr) != rd_cnt) addr_bad = 1'b1;
            rd_cnt++;
         end
         checks++;
         if ((goodColl || badColl) && !done) begin
            errors++;
            $display("FAIL stray_pulse: good=%0b bad=%0b done=%0b at cycle %0d",
                     goodColl, badColl, done, cyc);
         end
         if (done) begin
            done_seen++;
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
               e   = sbq.pop_front();
               got = goodColl ? (badColl ? 3 : 1) : (badColl ? 2 : 0);
               checks += 3;
               if (got != e.res) begin
                  errors++;
                  $display("FAIL result: got %0d expected %0d", got, e.res);
               end
               if (cyc - acc_cyc != e.lat) begin
                  errors++;
                  $display("FAIL latency: got %0d expected %0d", cyc - acc_cyc, e.lat);
               end
               if (rd_cnt != e.reads || addr_bad) begin
                  errors++;
                  $display("FAIL reads: got %0d (addr_bad=%0b) expected %0d in order",
                           rd_cnt, addr_bad, e.reads);
               end
            end
         end
         if (check_valid && check_ready) begin
            acc_cyc  = cyc + 1;
            rd_cnt   = 0;
            addr_bad = 1'b0;
            acc_seen++;
         end
      end
   end

   task automatic scramble();
      head_x    = XW'($urandom);
      head_y    = YW'($urandom);
      apple_x   = XW'($urandom);
      apple_y   = YW'($urandom);
      snake_len = LW'($urandom);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d checks outstanding, expected 0", sbq.size());
         sbq.delete();
      end
      @(negedge clk);
   endtask

   task automatic do_check(input int hx, input int hy, input int ax, input int ay,
                           input int len, input int hold);
      int n = 0;
      @(posedge clk); #1;
      head_x      = XW'(hx);
      head_y      = YW'(hy);
      apple_x     = XW'(ax);
      apple_y     = YW'(ay);
      snake_len   = LW'(len);
      check_valid = 1'b1;
      @(negedge clk);
      while (!check_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!check_ready) begin
         errors++;
         checks++;
         $display("FAIL ready_wait: ready=%0b expected 1", check_ready);
         check_valid = 1'b0;
         return;
      end
      sbq.push_back(model(hx, hy, ax, ay, len));
      @(posedge clk); #1;
      repeat (hold) begin
         scramble();
         @(posedge clk); #1;
      end
      check_valid = 1'b0;
      scramble();
      wait_drain();
   endtask

   task automatic expect_bit(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, got, want);
      end
   endtask

   task automatic expect_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation still running, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int d0, a0, len, sel, hx, hy, ax, ay, k;
      for (int i = 0; i < MAXL; i++) begin bx[i] = 0; by[i] = 11; end

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      expect_bit("rst_ready", check_ready, 1'b1);
      expect_bit("rst_done", done, 1'b0);
      expect_bit("rst_good", goodColl, 1'b0);
      expect_bit("rst_bad", badColl, 1'b0);
      expect_bit("rst_rd_en", body_rd_en, 1'b0);
      expect_int("rst_rd_addr", int'(body_rd_addr), 0);

      // apple eaten behind a 3-segment body
      bx[0] = 5; by[0] = 5; bx[1] = 4; by[1] = 5; bx[2] = 3; by[2] = 5;
      do_check(6, 5, 6, 5, 3, 0);
      // off-grid head beats apple
      do_check(16, 3, 16, 3, 3, 0);
      // self-hit at segment 1 of 5
      bx[3] = 2; by[3] = 5; bx[4] = 1; by[4] = 5;
      do_check(4, 5, 9, 9, 5, 0);
      // negative (all-ones) coordinates
      do_check(31, 2, 31, 2, 0, 0);
      do_check(2, 31, 3, 3, 5, 0);

      // empty body, valid held high through the busy cycles
      d0 = done_seen;
      a0 = acc_seen;
      do_check(2, 2, 9, 9, 0, 3);
      expect_int("hold_one_done", done_seen - d0, 1);
      expect_int("hold_one_accept", acc_seen - a0, 1);

      // reset during SCAN aborts the check
      for (int i = 0; i < 10; i++) begin bx[i] = i; by[i] = 11; end
      d0 = done_seen;
      @(posedge clk); #1;
      head_x = XW'(14); head_y = YW'(2); apple_x = XW'(14); apple_y = YW'(2);
      snake_len = LW'(10);
      check_valid = 1'b1;
      @(negedge clk);
      expect_bit("abort_pre_ready", check_ready, 1'b1);
      @(posedge clk); #1;
      check_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      expect_bit("abort_in_scan", body_rd_en, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      expect_bit("abort_ready", check_ready, 1'b1);
      expect_bit("abort_done", done, 1'b0);
      expect_bit("abort_rd_en", body_rd_en, 1'b0);
      repeat (20) @(negedge clk);
      expect_int("abort_no_pulse", done_seen - d0, 0);
      do_check(14, 2, 14, 2, 10, 0);

      // length clamp: 80 requested, 64 segments read, no hit
      for (int i = 0; i < MAXL; i++) begin bx[i] = i % GW; by[i] = i % 11; end
      do_check(15, 11, 15, 11, 80, 0);
      do_check(15, 11, 1, 1, 64, 1);

      // randomized checks
      for (int t = 0; t < 40; t++) begin
         len = $urandom_range(0, 70);
         for (int i = 0; i < MAXL; i++) begin
            bx[i] = $urandom_range(0, GW - 1);
            by[i] = $urandom_range(0, GH - 1);
         end
         hx  = $urandom_range(0, GW - 1);
         hy  = $urandom_range(0, GH - 1);
         sel = $urandom_range(0, 9);
         if (sel == 0) hx = $urandom_range(GW, 31);
         else if (sel == 1) hy = $urandom_range(GH, 31);
         else if (sel < 6 && len > 0) begin
            k  = $urandom_range(0, ((len > MAXL) ? MAXL : len) - 1);
            hx = bx[k];
            hy = by[k];
         end
         if ($urandom_range(0, 1) == 1) begin
            ax = hx; ay = hy;
         end else begin
            ax = $urandom_range(0, GW - 1);
            ay = $urandom_range(0, GH - 1);
         end
         do_check(hx, hy, ax, ay, len, $urandom_range(0, 3));
      end

      repeat (5) @(negedge clk);
      expect_int("scoreboard_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
